// File: rtl/abcd_pattern_checker.sv
// abcd_pattern_checker: monitors a stream of 4-bit {a,b,c,d} toggle patterns.
// Each accepted beat is judged against the two legal codes (X=0110, Y=1001) and
// against strict X/Y alternation. Matches and errors are counted (saturating),
// an error pulse is raised per errored beat, and a run of MAX_ERR consecutive
// errors locks the input out until rst or clr.
module abcd_pattern_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MAX_ERR = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_abcd_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_pulse_o,
    output logic             in_sync_o,
    output logic             locked_o
);

    typedef enum logic [1:0] {
        StHunt,
        StExpectX,
        StExpectY,
        StLockout
    } state_e;

    localparam logic [3:0]       CodeX  = 4'b0110;
    localparam logic [3:0]       CodeY  = 4'b1001;
    localparam logic [3:0]       MaxErr = 4'(MAX_ERR);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic             err_pulse_q, err_pulse_d;
    logic             in_sync_q, in_sync_d;
    logic             locked_q, locked_d;

    logic accept;
    logic is_x;
    logic is_y;
    logic beat_match;
    logic beat_err;

    // Handshake: never ready while locked or while a clear/reset is being applied.
    always_comb begin
        in_ready_o = !locked_q && !clr_i && !rst_i;
        accept     = in_valid_i && in_ready_o;
        is_x       = (in_abcd_i == CodeX);
        is_y       = (in_abcd_i == CodeY);
    end

    // Next-state, counter and registered-output logic for one accepted beat.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        consec_d    = consec_q;
        err_pulse_d = 1'b0;
        beat_match  = 1'b0;
        beat_err    = 1'b0;

        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (is_x) begin
                        state_d    = StExpectY;
                        beat_match = 1'b1;
                    end else if (is_y) begin
                        state_d    = StExpectX;
                        beat_match = 1'b1;
                    end else begin
                        state_d  = StHunt;
                        beat_err = 1'b1;
                    end
                end
                StExpectX: begin
                    if (is_x) begin
                        state_d    = StExpectY;
                        beat_match = 1'b1;
                    end else if (is_y) begin
                        // Repeated Y: resync on it, so X is expected next.
                        state_d  = StExpectX;
                        beat_err = 1'b1;
                    end else begin
                        state_d  = StHunt;
                        beat_err = 1'b1;
                    end
                end
                StExpectY: begin
                    if (is_y) begin
                        state_d    = StExpectX;
                        beat_match = 1'b1;
                    end else if (is_x) begin
                        // Repeated X: resync on it, so Y is expected next.
                        state_d  = StExpectY;
                        beat_err = 1'b1;
                    end else begin
                        state_d  = StHunt;
                        beat_err = 1'b1;
                    end
                end
                StLockout: begin
                    // Unreachable with accept set: in_ready is low here.
                    state_d = StLockout;
                end
            endcase
        end

        if (beat_match) begin
            consec_d = 4'd0;
            if (match_cnt_q != CntMax) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
        end

        if (beat_err) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != CntMax) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            // MAX_ERR <= 15, so the run counter locks before it could wrap.
            consec_d = consec_q + 4'd1;
            if (consec_d == MaxErr) begin
                state_d = StLockout;
            end
        end

        in_sync_d = (state_d == StExpectX) || (state_d == StExpectY);
        locked_d  = (state_d == StLockout);
    end

    // State and registered outputs; rst and clr both return to the reset state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q     <= StHunt;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            consec_q    <= 4'd0;
            err_pulse_q <= 1'b0;
            in_sync_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            consec_q    <= consec_d;
            err_pulse_q <= err_pulse_d;
            in_sync_q   <= in_sync_d;
            locked_q    <= locked_d;
        end
    end

    assign match_cnt_o = match_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_pulse_o = err_pulse_q;
    assign in_sync_o   = in_sync_q;
    assign locked_o    = locked_q;

endmodule

// File: tb/tb_abcd_pattern_checker.sv
// Directed bench for abcd_pattern_checker: a default instance (CNT_W=8, MAX_ERR=3)
// and a narrow instance (CNT_W=2, MAX_ERR=15) for counter saturation.
module tb_abcd_pattern_checker;

    localparam logic [3:0] X = 4'b0110;
    localparam logic [3:0] Y = 4'b1001;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_abcd;

    logic       ready_a, pulse_a, sync_a, locked_a;
    logic [7:0] match_a, err_a;
    logic       ready_b, pulse_b, sync_b, locked_b;
    logic [1:0] match_b, err_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    abcd_pattern_checker #(.CNT_W(8), .MAX_ERR(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (ready_a),
        .in_abcd_i   (in_abcd),
        .clr_i       (clr),
        .match_cnt_o (match_a),
        .err_cnt_o   (err_a),
        .err_pulse_o (pulse_a),
        .in_sync_o   (sync_a),
        .locked_o    (locked_a)
    );

    abcd_pattern_checker #(.CNT_W(2), .MAX_ERR(15)) dut_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (ready_b),
        .in_abcd_i   (in_abcd),
        .clr_i       (clr),
        .match_cnt_o (match_b),
        .err_cnt_o   (err_b),
        .err_pulse_o (pulse_b),
        .in_sync_o   (sync_b),
        .locked_o    (locked_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [3:0] abcd, input logic c, input logic r);
        in_valid = v;
        in_abcd  = abcd;
        clr      = c;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_abcd = 4'h0;

        // Reset
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst_ready_low", ready_a, 0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst_ready", ready_a, 1);
        chk("rst_match", match_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_sync", sync_a, 0);
        chk("rst_locked", locked_a, 0);

        // abcd ignored without valid
        cyc(1'b0, 4'hF, 1'b0, 1'b0);
        chk("idle_err", err_a, 0);

        // Alternating stream X,Y,X,Y,X
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("alt_b1_match", match_a, 1);
        chk("alt_b1_sync", sync_a, 1);
        cyc(1'b1, Y, 1'b0, 1'b0);
        chk("alt_b2_pulse", pulse_a, 0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("alt_b3_pulse", pulse_a, 0);
        cyc(1'b1, Y, 1'b0, 1'b0);
        chk("alt_b4_pulse", pulse_a, 0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("alt_match", match_a, 5);
        chk("alt_err", err_a, 0);
        chk("alt_pulse", pulse_a, 0);
        chk("alt_sync", sync_a, 1);

        // Repeat error X,X,Y
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        chk("clr_ready_low", ready_a, 0);
        chk("clr_match", match_a, 0);
        cyc(1'b1, X, 1'b0, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("rep_err", err_a, 1);
        chk("rep_pulse", pulse_a, 1);
        chk("rep_match", match_a, 1);
        chk("rep_sync", sync_a, 1);
        cyc(1'b1, Y, 1'b0, 1'b0);
        chk("rep_match2", match_a, 2);
        chk("rep_pulse_gone", pulse_a, 0);
        chk("rep_sync2", sync_a, 1);

        // Illegal code X,1111,Y
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("ill_err", err_a, 1);
        chk("ill_sync", sync_a, 0);
        chk("ill_pulse", pulse_a, 1);
        cyc(1'b1, Y, 1'b0, 1'b0);
        chk("ill_match", match_a, 2);
        chk("ill_sync2", sync_a, 1);

        // A match between errors restarts the consecutive run
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        chk("run_locked", locked_a, 0);
        chk("run_err", err_a, 4);

        // Lockout after three consecutive errors
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        chk("lk_b2_locked", locked_a, 0);
        chk("lk_b2_err", err_a, 2);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        chk("lk_locked", locked_a, 1);
        chk("lk_ready", ready_a, 0);
        chk("lk_err", err_a, 3);
        chk("lk_pulse", pulse_a, 1);
        chk("lk_sync", sync_a, 0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("lk_hold_match", match_a, 0);
        chk("lk_hold_err", err_a, 3);
        chk("lk_hold_pulse", pulse_a, 0);
        chk("lk_hold_locked", locked_a, 1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("lk_clr_locked", locked_a, 0);
        chk("lk_clr_err", err_a, 0);
        chk("lk_clr_ready", ready_a, 1);

        // Saturation on the CNT_W=2, MAX_ERR=15 instance
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        cyc(1'b1, Y, 1'b0, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        cyc(1'b1, Y, 1'b0, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("sat_match", match_b, 3);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("sat_p1", pulse_b, 1);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("sat_p2", pulse_b, 1);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("sat_p3", pulse_b, 1);
        chk("sat_err3", err_b, 3);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("sat_p4", pulse_b, 1);
        chk("sat_err4", err_b, 3);
        chk("sat_match_hold", match_b, 3);
        chk("sat_locked", locked_b, 0);

        // Mid-stream reset while in EXPECT_Y
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, X, 1'b0, 1'b0);
        chk("mr_pre_match", match_a, 1);
        in_valid = 1'b1; in_abcd = X; rst = 1'b1;
        #1;
        chk("mr_ready_low", ready_a, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; rst = 1'b0;
        #1;
        chk("mr_match", match_a, 0);
        chk("mr_err", err_a, 0);
        chk("mr_pulse", pulse_a, 0);
        chk("mr_sync", sync_a, 0);
        chk("mr_locked", locked_a, 0);
        chk("mr_ready", ready_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/abcd_pattern_checker.md
# abcd_pattern_checker

Downstream monitor for the 4-bit {a,b,c,d} toggle-pattern generator. It accepts one pattern per valid/ready handshake and checks each beat against the two legal codes, 4'b0110 and 4'b1001. It also checks that beats strictly alternate between the two codes. It counts matches and errors, reports sync status, and locks out input after a run of consecutive errors until software clears it.

## Interface
- CNT_W, 8: width of match_cnt and err_cnt; both counters saturate at all-ones.
- MAX_ERR, 3: number of consecutive errored beats that forces LOCKOUT; legal range 1..15.

- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a pattern beat is presented.
- in_ready  out  1  the checker can accept a beat; a beat is accepted when in_valid && in_ready.
- in_abcd  in  4  pattern beat; bit3=a, bit2=b, bit1=c, bit0=d.
- clr  in  1  synchronous clear; has the same effect as rst on state and counters.
- match_cnt  out  CNT_W  number of accepted beats judged correct.
- err_cnt  out  CNT_W  number of accepted beats judged wrong.
- err_pulse  out  1  one-cycle pulse, registered, in the cycle after an errored beat is accepted.
- in_sync  out  1  high in EXPECT_X or EXPECT_Y.
- locked  out  1  high in LOCKOUT.

## Operation
- Codes: X = 4'b0110 (d=0), Y = 4'b1001 (d=1). Any other value is illegal.
- FSM states: HUNT, EXPECT_X, EXPECT_Y, LOCKOUT. The reset state is HUNT.
- Only accepted beats change the FSM. With no beat accepted, the state holds.
- HUNT:
  - X accepted → EXPECT_Y, match +1.
  - Y accepted → EXPECT_X, match +1.
  - Illegal beat → stay in HUNT, error.
- EXPECT_X (EXPECT_Y is symmetric):
  - X accepted → EXPECT_Y, match +1.
  - Y accepted (repeat error) → EXPECT_X, error. This resyncs on the received code.
  - Illegal beat → HUNT, error.
- Consecutive-error counter (internal, 4 bits):
  - +1 on each errored beat; cleared on each matched beat.
  - When an errored beat brings it to MAX_ERR, the next state is LOCKOUT, overriding the HUNT/EXPECT transition above.
- LOCKOUT: in_ready=0. The block stays in LOCKOUT until rst or clr.
- in_ready = !locked && !clr && !rst. It is combinational from state and clr.
- Counters saturate. At all-ones, a further event leaves the count unchanged. err_pulse still fires.
- clr or rst: next state is HUNT. match_cnt, err_cnt, the consecutive-error counter and err_pulse all go to 0. clr has priority over a simultaneous beat, and that beat is not accepted because in_ready=0.

## Timing
- Reset values: in_ready=1 after the reset cycle (0 while rst=1), match_cnt=0, err_cnt=0, err_pulse=0, in_sync=0, locked=0.
- Latency: a beat accepted at edge N is reflected in the counters, err_pulse, in_sync and locked immediately after edge N. They are visible for the whole of cycle N+1.
- Throughput: 1 beat/cycle while in_ready=1. There are no bubbles between beats.
- in_ready drops in the cycle after the beat that entered LOCKOUT. No beat is accepted in that same cycle unless it was already the entering beat.
- A clr held for multiple cycles keeps the block in the reset state. Operation resumes on the first cycle with clr=0.
- in_abcd is sampled only on an accepting edge. Its value is ignored otherwise.

## Test plan
- Alternating stream: after reset, send X,Y,X,Y,X back-to-back → match_cnt=5, err_cnt=0, in_sync=1 from cycle 2, err_pulse never set.
- Repeat error: send X,X,Y → after beat 2, err_cnt=1 and err_pulse=1 for one cycle, state EXPECT_Y; after beat 3, match_cnt=2 and in_sync=1.
- Illegal code: send X then 4'b1111 → err_cnt=1, in_sync=0 (HUNT); a following Y gives match_cnt=2 and in_sync=1.
- Lockout (MAX_ERR=3): send 0000,0000,0000 → locked=1 and in_ready=0 after beat 3; a further in_valid with X gives no count change; pulse clr for 1 cycle → locked=0, counters=0, in_ready=1.
- Saturation (CNT_W=2): send 5 alternating beats → match_cnt=3; send 4 illegal beats with MAX_ERR=15 → err_cnt=3 and err_pulse fires on all 4.
- Mid-stream reset: assert rst together with in_valid and X while in EXPECT_Y → beat not accepted, all outputs at reset values the next cycle.
